apb_req_bridge: RTL and testbench
=================================

APB_REQ_BRIDGE -- requirements
Module: apb_req_bridge

Interface
REQ-001 Parameters SHALL be: APB_ADDR_WIDTH, default 32, APB address width; APB_DATA_WIDTH, default 32, APB data width; TIMEOUT_CYCLES, default 255, maximum ACCESS-phase wait cycles (range 1..255).
REQ-002 The block SHALL have one clock and a synchronous, active-high reset.
REQ-003 Ports SHALL be:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when high with req_valid.
- req_addr  in  APB_ADDR_WIDTH  byte address.
- req_we  in  1  1=write, 0=read.
- req_wdata  in  APB_DATA_WIDTH  write data.
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  APB_DATA_WIDTH  read data, 0 for writes and errors.
- resp_err  out  1  slave error, decode error or timeout.
- paddr, pwdata, pwrite, psel, penable  out  APB master signals (widths per APB_BUS).
- prdata, pready, pslverr  in  APB slave return signals.

Function
REQ-004 The FSM SHALL have four states: IDLE, SETUP, ACCESS and RESP.
REQ-005 req_ready SHALL be high only in IDLE; a handshake SHALL occur when req_valid and req_ready are both high.
REQ-006 On a handshake, the block SHALL register req_addr, req_we and req_wdata into paddr, pwrite and pwdata, which SHALL stay stable until the next handshake.
REQ-007 A decoded address SHALL move IDLE->SETUP; an undecoded address SHALL move IDLE->RESP with resp_err=1 and psel never asserted.
REQ-008 Decode SHALL hit on 0x1A10_0000..0x1A10_8FFF (UART, GPIO, SPI, TIMER, EVENT_UNIT, I2C, FLL, SOC_CTRL, ACC) or 0x1A11_0000..0x1A11_7FFF (DEBUG), with inclusive bounds.
REQ-009 SETUP SHALL drive psel=1 and penable=0 for exactly one cycle, then move to ACCESS.
REQ-010 ACCESS SHALL drive psel=1 and penable=1 until pready=1 is sampled; it SHALL then capture prdata (reads only) and pslverr and move to RESP.
REQ-011 A wait counter SHALL clear on SETUP entry and increment each ACCESS cycle with pready=0.
REQ-012 If the wait counter equals TIMEOUT_CYCLES while pready=0, the block SHALL move to RESP with resp_err=1 and resp_rdata=0.
REQ-013 On timeout, psel and penable SHALL be low from the next cycle.
REQ-014 If pready=1 arrives in the same cycle the timeout would fire, pready SHALL win and the transfer SHALL complete normally.
REQ-015 RESP SHALL assert resp_valid for exactly one cycle, with psel=0 and penable=0, then return to IDLE; the consumer SHALL NOT back-pressure.
REQ-016 resp_rdata and resp_err SHALL be valid only while resp_valid=1 and SHALL be 0 otherwise.
REQ-017 Latency with a zero-wait slave SHALL be: handshake in cycle N, SETUP N+1, ACCESS N+2, resp_valid N+3. Each slave wait state SHALL add one cycle.
REQ-018 Latency for a decode error SHALL be: handshake in cycle N, resp_valid N+1.
REQ-019 Back-to-back requests SHALL be separated by at least one cycle with psel=0 (the RESP cycle plus the IDLE cycle).
REQ-020 penable SHALL never be high while psel=0.

Reset
REQ-021 While rst=1 at a rising edge, the block SHALL enter IDLE and clear the wait counter.
REQ-022 Reset values SHALL be: req_ready=0 during reset (1 on the first IDLE cycle after), resp_valid=0, resp_rdata=0, resp_err=0, psel=0, penable=0, paddr=0, pwdata=0, pwrite=0.
REQ-023 Reset asserted mid-transfer SHALL abort the transfer with no resp_valid pulse; psel and penable SHALL be low after that edge.

Structure
REQ-024 The package apb_bridge_pkg SHALL hold the FSM state enum, the two decode window start/end constants and TIMEOUT_CYCLES_DEFAULT.
REQ-025 Address decode SHALL be one combinational sub-module, apb_addr_decode (input addr, output hit). The FSM, capture registers and wait counter SHALL live in apb_req_bridge.
REQ-026 The APB side SHALL connect to an APB_BUS Master modport in the instantiating wrapper.

Verification
REQ-027 The bench SHALL cover these directed scenarios:
- Read 0x1A10_1000, pready=1 in first ACCESS cycle, prdata=0xDEAD_BEEF -> resp_valid at N+3, resp_rdata=0xDEAD_BEEF, resp_err=0.
- Write 0x1A11_7FFC, data 0x0000_00A5, 3 wait states -> pwdata stable across SETUP/ACCESS, resp_valid at N+6, resp_rdata=0, resp_err=0.
- Read 0x1A10_9000 (gap) -> no psel, resp_valid at N+1, resp_err=1.
- TIMEOUT_CYCLES=4, pready held 0 -> psel low after 4 wait cycles, resp_err=1, resp_rdata=0.
- pslverr=1 with pready=1 on a read of 0x1A10_7000 -> resp_err=1.
- rst asserted during ACCESS -> no resp_valid; psel=0 next cycle; the next request completes normally.

Source files
------------

// File: rtl/apb_bridge_pkg.sv
// Shared types and constants for the request-to-APB bridge: FSM states,
// peripheral decode windows and the default ACCESS-phase timeout.
package apb_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  // Window 0 spans UART..ACC, window 1 is the debug unit; bounds are inclusive.
  localparam logic [31:0] WIN0_START = 32'h1A10_0000;
  localparam logic [31:0] WIN0_END   = 32'h1A10_8FFF;
  localparam logic [31:0] WIN1_START = 32'h1A11_0000;
  localparam logic [31:0] WIN1_END   = 32'h1A11_7FFF;

  localparam int NUM_WINDOWS = 2;

  localparam int TIMEOUT_CYCLES_DEFAULT = 255;

  function automatic logic [31:0] win_start(input int idx);
    logic [31:0] result;
    case (idx)
      0:       result = WIN0_START;
      1:       result = WIN1_START;
      default: result = 32'hFFFF_FFFF;
    endcase
    return result;
  endfunction

  function automatic logic [31:0] win_end(input int idx);
    logic [31:0] result;
    case (idx)
      0:       result = WIN0_END;
      1:       result = WIN1_END;
      default: result = 32'h0000_0000;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/apb_addr_decode.sv
// Combinational address decoder: hit is high when addr falls inside any
// peripheral window listed in apb_bridge_pkg.
module apb_addr_decode
  import apb_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic                  hit
);

  // Compare at no less than 32 bits so the window constants never truncate.
  localparam int CW = (ADDR_WIDTH > 32) ? ADDR_WIDTH : 32;

  logic [CW-1:0]          addr_ext;
  logic [NUM_WINDOWS-1:0] win_hit;

  assign addr_ext = CW'(addr);

  generate
    for (genvar gi = 0; gi < NUM_WINDOWS; gi++) begin : g_win
      assign win_hit[gi] = (addr_ext >= CW'(win_start(gi))) &&
                           (addr_ext <= CW'(win_end(gi)));
    end
  endgenerate

  assign hit = |win_hit;

endmodule

// File: rtl/apb_req_bridge.sv
// Single-outstanding valid/ready request port to APB master bridge with
// address decode, ACCESS-phase timeout and a one-cycle response pulse.
module apb_req_bridge
  import apb_bridge_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,

  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [APB_ADDR_WIDTH-1:0] req_addr,
  input  logic                      req_we,
  input  logic [APB_DATA_WIDTH-1:0] req_wdata,

  output logic                      resp_valid,
  output logic [APB_DATA_WIDTH-1:0] resp_rdata,
  output logic                      resp_err,

  output logic [APB_ADDR_WIDTH-1:0] paddr,
  output logic [APB_DATA_WIDTH-1:0] pwdata,
  output logic                      pwrite,
  output logic                      psel,
  output logic                      penable,
  input  logic [APB_DATA_WIDTH-1:0] prdata,
  input  logic                      pready,
  input  logic                      pslverr
);

  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

  state_t                    state_reg;
  logic [7:0]                wait_cnt_reg;
  logic [7:0]                wait_cnt_next;
  logic [APB_ADDR_WIDTH-1:0] paddr_reg;
  logic [APB_DATA_WIDTH-1:0] pwdata_reg;
  logic                      pwrite_reg;
  logic                      psel_reg;
  logic                      penable_reg;
  logic                      resp_valid_reg;
  logic [APB_DATA_WIDTH-1:0] resp_rdata_reg;
  logic                      resp_err_reg;
  logic                      addr_hit;

  apb_addr_decode #(
    .ADDR_WIDTH (APB_ADDR_WIDTH)
  ) u_decode (
    .addr (req_addr),
    .hit  (addr_hit)
  );

  // Ready is held low while reset is asserted even though the state is IDLE.
  assign req_ready     = (state_reg == ST_IDLE) && !rst;
  assign wait_cnt_next = wait_cnt_reg + 8'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      wait_cnt_reg   <= '0;
      paddr_reg      <= '0;
      pwdata_reg     <= '0;
      pwrite_reg     <= 1'b0;
      psel_reg       <= 1'b0;
      penable_reg    <= 1'b0;
      resp_valid_reg <= 1'b0;
      resp_rdata_reg <= '0;
      resp_err_reg   <= 1'b0;
    end else begin
      // Response fields are zero except in the single RESP cycle.
      resp_valid_reg <= 1'b0;
      resp_rdata_reg <= '0;
      resp_err_reg   <= 1'b0;

      case (state_reg)
        ST_IDLE: begin
          if (req_valid) begin
            paddr_reg  <= req_addr;
            pwdata_reg <= req_wdata;
            pwrite_reg <= req_we;
            if (addr_hit) begin
              state_reg    <= ST_SETUP;
              psel_reg     <= 1'b1;
              penable_reg  <= 1'b0;
              wait_cnt_reg <= '0;
            end else begin
              state_reg      <= ST_RESP;
              resp_valid_reg <= 1'b1;
              resp_err_reg   <= 1'b1;
            end
          end
        end

        ST_SETUP: begin
          penable_reg <= 1'b1;
          state_reg   <= ST_ACCESS;
        end

        ST_ACCESS: begin
          if (pready) begin
            psel_reg       <= 1'b0;
            penable_reg    <= 1'b0;
            resp_valid_reg <= 1'b1;
            resp_err_reg   <= pslverr;
            resp_rdata_reg <= (pwrite_reg || pslverr) ? '0 : prdata;
            state_reg      <= ST_RESP;
          end else if (wait_cnt_next == TIMEOUT_LIMIT) begin
            // This wait cycle would bring the count to the limit: abort.
            psel_reg       <= 1'b0;
            penable_reg    <= 1'b0;
            resp_valid_reg <= 1'b1;
            resp_err_reg   <= 1'b1;
            state_reg      <= ST_RESP;
          end else begin
            wait_cnt_reg <= wait_cnt_next;
          end
        end

        ST_RESP: begin
          state_reg <= ST_IDLE;
        end

        default: begin
          psel_reg    <= 1'b0;
          penable_reg <= 1'b0;
          state_reg   <= ST_IDLE;
        end
      endcase
    end
  end

  assign paddr      = paddr_reg;
  assign pwdata     = pwdata_reg;
  assign pwrite     = pwrite_reg;
  assign psel       = psel_reg;
  assign penable    = penable_reg;
  assign resp_valid = resp_valid_reg;
  assign resp_rdata = resp_rdata_reg;
  assign resp_err   = resp_err_reg;

endmodule

// File: tb/tb_apb_req_bridge.sv
// Directed self-checking bench for apb_req_bridge with a small in-line APB
// slave whose wait states, read data and error flag are set per scenario.
module tb_apb_req_bridge;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_we;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic        pwrite;
  logic        psel;
  logic        penable;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  int          n_cmp;
  int          n_bad;
  int          cyc;
  int          slv_waits;
  int          slv_cnt;
  logic [31:0] slv_rdata;
  logic        slv_err;

  apb_req_bridge #(
    .APB_ADDR_WIDTH (32),
    .APB_DATA_WIDTH (32),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_we     (req_we),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .paddr      (paddr),
    .pwdata     (pwdata),
    .pwrite     (pwrite),
    .psel       (psel),
    .penable    (penable),
    .prdata     (prdata),
    .pready     (pready),
    .pslverr    (pslverr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to the next falling edge, update the slave model, check penable=>psel.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (psel && penable) begin
      if (slv_cnt >= slv_waits) begin
        pready  = 1'b1;
        prdata  = slv_rdata;
        pslverr = slv_err;
      end else begin
        pready  = 1'b0;
        prdata  = 32'h0;
        pslverr = 1'b0;
        slv_cnt++;
      end
    end else begin
      pready  = 1'b0;
      prdata  = 32'h0;
      pslverr = 1'b0;
      slv_cnt = 0;
    end
    n_cmp++;
    if (penable && !psel) begin
      n_bad++;
      $display("FAIL penable_without_psel: cycle %0d got penable=1 psel=0 required penable=0", cyc);
    end
  endtask

  // Present one request in an IDLE cycle N; returns at the falling edge of N+1.
  task automatic issue(input logic [31:0] addr, input logic we, input logic [31:0] wdata);
    $display("xfer: addr=%h we=%b wdata=%h waits=%0d", addr, we, wdata, slv_waits);
    req_valid = 1'b1;
    req_addr  = addr;
    req_we    = we;
    req_wdata = wdata;
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL issue_ready: got req_ready=%b required 1", req_ready);
    end
    step();
    req_valid = 1'b0;
  endtask

  // Bounded wait for the bridge to come back to IDLE.
  task automatic drain();
    int k;
    k = 0;
    while (req_ready !== 1'b1 && k < 40) begin
      step();
      k++;
    end
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL drain_timeout: got req_ready=%b after %0d cycles required 1", req_ready, k);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    n_cmp++;
    if (req_ready !== 1'b0) begin n_bad++; $display("FAIL rst_req_ready: got %b required 0", req_ready); end
    n_cmp++;
    if ({resp_valid, resp_err, psel, penable, pwrite} !== 5'b0) begin
      n_bad++; $display("FAIL rst_ctrl: got %b required 00000", {resp_valid, resp_err, psel, penable, pwrite});
    end
    n_cmp++;
    if ({paddr, pwdata, resp_rdata} !== 96'h0) begin
      n_bad++; $display("FAIL rst_data: got paddr=%h pwdata=%h rdata=%h required all 0", paddr, pwdata, resp_rdata);
    end
    rst = 1'b0;
    step();
    n_cmp++;
    if (req_ready !== 1'b1) begin n_bad++; $display("FAIL rst_release_ready: got %b required 1", req_ready); end
  endtask

  task automatic test_read_zero_wait();
    slv_waits = 0; slv_rdata = 32'hDEAD_BEEF; slv_err = 1'b0;
    issue(32'h1A10_1000, 1'b0, 32'h0);
    n_cmp++;
    if ({psel, penable, resp_valid} !== 3'b100) begin
      n_bad++; $display("FAIL rd_setup: got psel/penable/resp_valid=%b required 100", {psel, penable, resp_valid});
    end
    n_cmp++;
    if (paddr !== 32'h1A10_1000 || pwrite !== 1'b0) begin
      n_bad++; $display("FAIL rd_paddr: got %h/%b required 1a101000/0", paddr, pwrite);
    end
    step();
    n_cmp++;
    if ({psel, penable, resp_valid} !== 3'b110) begin
      n_bad++; $display("FAIL rd_access: got psel/penable/resp_valid=%b required 110", {psel, penable, resp_valid});
    end
    step();
    n_cmp++;
    if ({resp_valid, resp_err, psel, penable} !== 4'b1000) begin
      n_bad++; $display("FAIL rd_resp_flags: got valid/err/psel/penable=%b required 1000", {resp_valid, resp_err, psel, penable});
    end
    n_cmp++;
    if (resp_rdata !== 32'hDEAD_BEEF) begin
      n_bad++; $display("FAIL rd_resp_rdata: got %h required deadbeef", resp_rdata);
    end
    step();
    n_cmp++;
    if ({resp_valid, resp_err, resp_rdata} !== 34'h0 || req_ready !== 1'b1) begin
      n_bad++; $display("FAIL rd_after_resp: got valid=%b err=%b rdata=%h ready=%b required 0/0/0/1", resp_valid, resp_err, resp_rdata, req_ready);
    end
  endtask

  task automatic test_write_wait3();
    slv_waits = 3; slv_rdata = 32'h5555_5555; slv_err = 1'b0;
    issue(32'h1A11_7FFC, 1'b1, 32'h0000_00A5);
    n_cmp++;
    if (psel !== 1'b1 || pwrite !== 1'b1 || pwdata !== 32'hA5) begin
      n_bad++; $display("FAIL wr_setup: got psel=%b pwrite=%b pwdata=%h required 1/1/000000a5", psel, pwrite, pwdata);
    end
    for (int k = 2; k <= 5; k++) begin
      step();
      n_cmp++;
      if (psel !== 1'b1 || penable !== 1'b1 || pwdata !== 32'hA5 || resp_valid !== 1'b0) begin
        n_bad++; $display("FAIL wr_access_n%0d: got psel=%b penable=%b pwdata=%h resp_valid=%b required 1/1/000000a5/0", k, psel, penable, pwdata, resp_valid);
      end
    end
    step();
    n_cmp++;
    if (resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_rdata !== 32'h0) begin
      n_bad++; $display("FAIL wr_resp: got valid=%b err=%b rdata=%h required 1/0/00000000", resp_valid, resp_err, resp_rdata);
    end
    n_cmp++;
    if (paddr !== 32'h1A11_7FFC || pwdata !== 32'hA5) begin
      n_bad++; $display("FAIL wr_hold: got paddr=%h pwdata=%h required 1a117ffc/000000a5", paddr, pwdata);
    end
    drain();
  endtask

  task automatic test_decode_error();
    slv_waits = 0; slv_err = 1'b0;
    issue(32'h1A10_9000, 1'b0, 32'h0);
    n_cmp++;
    if ({resp_valid, resp_err, psel, penable} !== 4'b1100 || resp_rdata !== 32'h0) begin
      n_bad++; $display("FAIL dec_err_resp: got valid/err/psel/penable=%b rdata=%h required 1100/00000000", {resp_valid, resp_err, psel, penable}, resp_rdata);
    end
    step();
    n_cmp++;
    if (resp_valid !== 1'b0 || psel !== 1'b0 || req_ready !== 1'b1) begin
      n_bad++; $display("FAIL dec_err_after: got valid=%b psel=%b ready=%b required 0/0/1", resp_valid, psel, req_ready);
    end
  endtask

  task automatic test_decode_bounds();
    logic [31:0] addrs [6];
    logic        hits  [6];
    addrs = '{32'h1A0F_FFFF, 32'h1A10_0000, 32'h1A10_8FFF, 32'h1A10_FFFF, 32'h1A11_0000, 32'h1A11_8000};
    hits  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    slv_waits = 0; slv_rdata = 32'h1; slv_err = 1'b0;
    for (int i = 0; i < 6; i++) begin
      issue(addrs[i], 1'b0, 32'h0);
      n_cmp++;
      if (psel !== hits[i] || resp_err !== !hits[i]) begin
        n_bad++; $display("FAIL bound_%h: got psel=%b resp_err=%b required %b/%b", addrs[i], psel, resp_err, hits[i], !hits[i]);
      end
      drain();
    end
  endtask

  task automatic test_timeout();
    slv_waits = 255; slv_rdata = 32'hFFFF_FFFF; slv_err = 1'b0;
    issue(32'h1A10_2000, 1'b0, 32'h0);
    for (int k = 2; k <= 5; k++) begin
      step();
      n_cmp++;
      if (psel !== 1'b1 || penable !== 1'b1 || resp_valid !== 1'b0) begin
        n_bad++; $display("FAIL to_wait_n%0d: got psel=%b penable=%b resp_valid=%b required 1/1/0", k, psel, penable, resp_valid);
      end
    end
    step();
    n_cmp++;
    if ({psel, penable, resp_valid, resp_err} !== 4'b0011 || resp_rdata !== 32'h0) begin
      n_bad++; $display("FAIL to_resp: got psel/penable/valid/err=%b rdata=%h required 0011/00000000", {psel, penable, resp_valid, resp_err}, resp_rdata);
    end
    drain();
  endtask

  task automatic test_pready_beats_timeout();
    slv_waits = 3; slv_rdata = 32'hCAFE_F00D; slv_err = 1'b0;
    issue(32'h1A10_3000, 1'b0, 32'h0);
    repeat (4) step();
    n_cmp++;
    if (pready !== 1'b1 || psel !== 1'b1) begin
      n_bad++; $display("FAIL race_setup: got pready=%b psel=%b required 1/1", pready, psel);
    end
    step();
    n_cmp++;
    if (resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_rdata !== 32'hCAFE_F00D) begin
      n_bad++; $display("FAIL race_resp: got valid=%b err=%b rdata=%h required 1/0/cafef00d", resp_valid, resp_err, resp_rdata);
    end
    drain();
  endtask

  task automatic test_slave_error();
    slv_waits = 0; slv_rdata = 32'h1234_5678; slv_err = 1'b1;
    issue(32'h1A10_7000, 1'b0, 32'h0);
    step();
    step();
    n_cmp++;
    if (resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_rdata !== 32'h0) begin
      n_bad++; $display("FAIL slverr_resp: got valid=%b err=%b rdata=%h required 1/1/00000000", resp_valid, resp_err, resp_rdata);
    end
    slv_err = 1'b0;
    drain();
  endtask

  task automatic test_back_to_back();
    slv_waits = 0; slv_rdata = 32'h0000_0011; slv_err = 1'b0;
    issue(32'h1A10_4000, 1'b0, 32'h0);
    step();
    step();
    req_valid = 1'b1; req_addr = 32'h1A10_5000; req_we = 1'b1; req_wdata = 32'h0000_0022;
    n_cmp++;
    if (resp_valid !== 1'b1 || psel !== 1'b0 || resp_rdata !== 32'h11) begin
      n_bad++; $display("FAIL b2b_resp: got valid=%b psel=%b rdata=%h required 1/0/00000011", resp_valid, psel, resp_rdata);
    end
    step();
    n_cmp++;
    if (psel !== 1'b0 || req_ready !== 1'b1 || paddr !== 32'h1A10_4000) begin
      n_bad++; $display("FAIL b2b_idle: got psel=%b ready=%b paddr=%h required 0/1/1a104000", psel, req_ready, paddr);
    end
    $display("xfer: addr=%h we=%b wdata=%h waits=%0d", req_addr, req_we, req_wdata, slv_waits);
    step();
    req_valid = 1'b0;
    n_cmp++;
    if (psel !== 1'b1 || paddr !== 32'h1A10_5000 || pwdata !== 32'h22 || pwrite !== 1'b1) begin
      n_bad++; $display("FAIL b2b_second: got psel=%b paddr=%h pwdata=%h pwrite=%b required 1/1a105000/00000022/1", psel, paddr, pwdata, pwrite);
    end
    drain();
  endtask

  task automatic test_reset_mid_access();
    slv_waits = 255; slv_rdata = 32'h0; slv_err = 1'b0;
    issue(32'h1A10_6000, 1'b0, 32'h0);
    step();
    n_cmp++;
    if (penable !== 1'b1) begin n_bad++; $display("FAIL rstmid_access: got penable=%b required 1", penable); end
    rst = 1'b1;
    step();
    n_cmp++;
    if ({psel, penable, resp_valid, req_ready} !== 4'b0000 || paddr !== 32'h0) begin
      n_bad++; $display("FAIL rstmid_abort: got psel/penable/valid/ready=%b paddr=%h required 0000/00000000", {psel, penable, resp_valid, req_ready}, paddr);
    end
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      n_cmp++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
        n_bad++; $display("FAIL rstmid_quiet_%0d: got valid=%b ready=%b required 0/1", k, resp_valid, req_ready);
      end
    end
    slv_waits = 0; slv_rdata = 32'h0BAD_F00D;
    issue(32'h1A10_0004, 1'b0, 32'h0);
    step();
    step();
    n_cmp++;
    if (resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_rdata !== 32'h0BAD_F00D) begin
      n_bad++; $display("FAIL rstmid_next: got valid=%b err=%b rdata=%h required 1/0/0badf00d", resp_valid, resp_err, resp_rdata);
    end
    drain();
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0;
    slv_waits = 0; slv_cnt = 0; slv_rdata = 32'h0; slv_err = 1'b0;
    rst = 1'b1; req_valid = 1'b0; req_addr = 32'h0; req_we = 1'b0; req_wdata = 32'h0;
    prdata = 32'h0; pready = 1'b0; pslverr = 1'b0;

    test_reset();
    test_read_zero_wait();
    test_write_wait3();
    test_decode_error();
    test_decode_bounds();
    test_timeout();
    test_pready_beats_timeout();
    test_slave_error();
    test_back_to_back();
    test_reset_mid_access();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
